// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared types and constants for the LED counter controller.
//   mode_e     : operating mode encoding (MANUAL/AUTO_UP/AUTO_DOWN)
//   BTN_*      : bit positions of the buttons within the button bus
//   COUNT_W    : width of the LED count
//   count_step : one +1/-1 step of the count. It saturates when
//                COUNTER_CTRL_SATURATE_EN is defined and wraps otherwise.
package counter_ctrl_pkg;

  localparam int unsigned COUNT_W   = 4;
  localparam int unsigned NUM_BTN   = 4;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_MODE  = 2;
  localparam int unsigned BTN_CLEAR = 3;

  typedef enum logic [1:0] {
    MODE_MANUAL    = 2'd0,
    MODE_AUTO_UP   = 2'd1,
    MODE_AUTO_DOWN = 2'd2
  } mode_e;

  // Single count step in the requested direction
  function automatic logic [COUNT_W-1:0] count_step(input logic [COUNT_W-1:0] v,
                                                     input logic              up);
    logic [COUNT_W-1:0] res;
    if (up) begin
      res = v + COUNT_W'(1);
`ifdef COUNTER_CTRL_SATURATE_EN
      if (v == '1) res = v;
`endif
    end else begin
      res = v - COUNT_W'(1);
`ifdef COUNTER_CTRL_SATURATE_EN
      if (v == '0) res = v;
`endif
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_ctrl_tick_gen.sv
// tick_gen: free-running period counter that emits a one-cycle strobe every
// CYCLES clocks while enabled.
//   clk, rst : clock, asynchronous active-high reset
//   en       : run enable; the counter is held at 0 while low
//   restart  : synchronously returns the counter to 0 (re-phases the strobe)
//   tick     : registered strobe, high while the counter sits at CYCLES-1
module tick_gen #(
  parameter int unsigned CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_tick;

  // Next count: cleared when disabled/restarted, wraps after LAST
  always_comb begin
    w_cnt_next = r_cnt;
    if (!en || restart) begin
      w_cnt_next = '0;
    end else if (r_cnt == LAST) begin
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // The strobe is registered from the next count so it aligns with r_cnt==LAST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= (w_cnt_next == LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: button-driven sequencer for the 4-bit LED counter.
// It synchronizes the buttons, detects presses, arbitrates them
// (clear > mode > up > down) and steps the count manually or once per
// CYCLES_PER_SECOND clocks in the auto modes.
//   clk, rst : clock, asynchronous active-high reset
//   buttons  : raw async buttons [0] up, [1] down, [2] mode, [3] clear
//   leds     : current count
//   mode     : current mode (mode_e)
//   tick     : auto-step strobe
// Build option: define COUNTER_CTRL_SATURATE_EN to make the count saturate.
// By default it wraps modulo 16.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SECOND = 100_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   buttons,
  output logic [3:0]   leds,
  output logic [1:0]   mode,
  output logic         tick
);

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_hist;
  logic [NUM_BTN-1:0] w_press;

  mode_e              r_mode;
  mode_e              w_mode_next;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_next;

  logic               w_auto;
  logic               w_restart;
  logic               w_tick;

  // Two-flop synchronizer plus history. Reset high so that a button held
  // across reset release does not register as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_hist  <= '1;
    end else begin
      r_sync1 <= buttons;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_press   = r_sync2 & ~r_hist;
  assign w_auto    = (r_mode == MODE_AUTO_UP) || (r_mode == MODE_AUTO_DOWN);
  assign w_restart = w_press[BTN_CLEAR] | w_press[BTN_MODE];

  tick_gen #(
    .CYCLES (CYCLES_PER_SECOND)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (w_auto),
    .restart (w_restart),
    .tick    (w_tick)
  );

  // Mode and count state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= MODE_MANUAL;
      r_count <= '0;
    end else begin
      r_mode  <= w_mode_next;
      r_count <= w_count_next;
    end
  end

  // Arbitration, next mode and next count. Any press consumes the cycle, so a
  // coincident tick is dropped.
  always_comb begin
    w_mode_next  = r_mode;
    w_count_next = r_count;
    if (w_press[BTN_CLEAR]) begin
      w_count_next = '0;
    end else if (w_press[BTN_MODE]) begin
      case (r_mode)
        MODE_MANUAL:  w_mode_next = MODE_AUTO_UP;
        MODE_AUTO_UP: w_mode_next = MODE_AUTO_DOWN;
        default:      w_mode_next = MODE_MANUAL;
      endcase
    end else if (w_press[BTN_UP]) begin
      if (r_mode == MODE_MANUAL) w_count_next = count_step(r_count, 1'b1);
    end else if (w_press[BTN_DOWN]) begin
      if (r_mode == MODE_MANUAL) w_count_next = count_step(r_count, 1'b0);
    end else if (w_tick) begin
      if (r_mode == MODE_AUTO_UP)   w_count_next = count_step(r_count, 1'b1);
      if (r_mode == MODE_AUTO_DOWN) w_count_next = count_step(r_count, 1'b0);
    end
    // The unused encoding falls back to MANUAL
    if (!(r_mode inside {MODE_MANUAL, MODE_AUTO_UP, MODE_AUTO_DOWN})) begin
      w_mode_next = MODE_MANUAL;
    end
  end

  assign leds = r_count;
  assign mode = r_mode;
  assign tick = w_tick;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: self-checking bench for counter_ctrl with CYCLES_PER_SECOND=8.
// A monitor pops expected LED values from a scoreboard queue on every LED change.
// Latency and timing points are checked directly.
// Covers both builds through COUNTER_CTRL_SATURATE_EN.
module tb_counter_ctrl;

  localparam int unsigned CPS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] buttons = 4'd0;
  logic [3:0] leds;
  logic [1:0] mode;
  logic       tick;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] sb_q[$];
  logic [3:0] model_leds = 4'd0;
  logic [1:0] model_mode = 2'd0;
  logic [3:0] prev_leds  = 4'd0;
  logic       mon_en     = 1'b0;

  counter_ctrl #(.CYCLES_PER_SECOND(CPS)) dut (
    .clk     (clk),
    .rst     (rst),
    .buttons (buttons),
    .leds    (leds),
    .mode    (mode),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference stepping, written independently of the RTL helper
  function automatic logic [3:0] m_inc(input logic [3:0] v);
    int r;
`ifdef COUNTER_CTRL_SATURATE_EN
    r = (int'(v) >= 15) ? 15 : int'(v) + 1;
`else
    r = (int'(v) + 1) % 16;
`endif
    return 4'(r);
  endfunction

  function automatic logic [3:0] m_dec(input logic [3:0] v);
    int r;
`ifdef COUNTER_CTRL_SATURATE_EN
    r = (v == 4'd0) ? 0 : int'(v) - 1;
`else
    r = (int'(v) + 15) % 16;
`endif
    return 4'(r);
  endfunction

  function automatic logic [1:0] m_next_mode(input logic [1:0] m);
    return (m == 2'd0) ? 2'd1 : (m == 2'd1) ? 2'd2 : 2'd0;
  endfunction

  // Scoreboard monitor: every LED change must match the next queued value
  always @(negedge clk) begin
    if (mon_en && (leds !== prev_leds)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_change", 32'(leds), 32'(prev_leds));
      end else begin
        check("sb_leds", 32'(leds), 32'(sb_q.pop_front()));
      end
      prev_leds = leds;
    end
  end

  function automatic void expect_leds(input logic [3:0] v);
    if (v != model_leds) sb_q.push_back(v);
  endfunction

  // Raise btn at a negedge (first sampled at edge k).
  // Check no change at k+1 and the update at k+2, then hold and release.
  task automatic press(input logic [3:0] btn, input logic [3:0] exp_leds,
                       input logic [1:0] exp_mode, input int hold);
    logic [3:0] old_leds;
    logic [1:0] old_mode;
    old_leds = model_leds;
    old_mode = model_mode;
    @(negedge clk);
    buttons = btn;
    expect_leds(exp_leds);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_leds_k1", 32'(leds), 32'(old_leds));
    check("lat_mode_k1", 32'(mode), 32'(old_mode));
    @(posedge clk); #1;
    check("upd_leds_k2", 32'(leds), 32'(exp_leds));
    check("upd_mode_k2", 32'(mode), 32'(exp_mode));
    model_leds = exp_leds;
    model_mode = exp_mode;
    repeat (hold) @(posedge clk);
    #1;
    check("hold_single", 32'(leds), 32'(exp_leds));
    @(negedge clk);
    buttons = 4'd0;
  endtask

  // Call within one cycle after entering auto or after the previous step
  task automatic auto_step(input logic up);
    logic [3:0] nxt;
    nxt = up ? m_inc(model_leds) : m_dec(model_leds);
    repeat (CPS - 1) @(posedge clk);
    #1;
    check("step_early_leds", 32'(leds), 32'(model_leds));
    check("tick_high", 32'(tick), 32'd1);
    expect_leds(nxt);
    @(posedge clk); #1;
    check("step_leds", 32'(leds), 32'(nxt));
    check("tick_low", 32'(tick), 32'd0);
    model_leds = nxt;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Manual stepping, first press held for 20 cycles
    press(4'b0001, m_inc(model_leds), 2'd0, 20);
    press(4'b0001, m_inc(model_leds), 2'd0, 2);
    press(4'b0001, m_inc(model_leds), 2'd0, 2);
    press(4'b0010, m_dec(model_leds), 2'd0, 2);
    check("manual_seq_end", 32'(leds), 32'd2);

    // Arbitration: clear beats up, then up beats down
    press(4'b0001, m_inc(model_leds), 2'd0, 1);
    press(4'b0001, m_inc(model_leds), 2'd0, 1);
    press(4'b0001, m_inc(model_leds), 2'd0, 1);
    press(4'b1001, 4'd0, 2'd0, 1);
    for (int i = 0; i < 5; i++) press(4'b0001, m_inc(model_leds), 2'd0, 1);
    press(4'b0011, 4'd6, 2'd0, 1);

    // Manual down at 0, then climb to 15
    press(4'b1000, 4'd0, 2'd0, 1);
    press(4'b0010, m_dec(model_leds), 2'd0, 1);
    while (model_leds != 4'd15) press(4'b0001, m_inc(model_leds), 2'd0, 1);

    // Auto up from 15 (boundary), auto down, then freeze in manual
    press(4'b0100, model_leds, m_next_mode(model_mode), 0);
    auto_step(1'b1);
    auto_step(1'b1);
    press(4'b0100, model_leds, m_next_mode(model_mode), 0);
    auto_step(1'b0);
    auto_step(1'b0);
    press(4'b0100, model_leds, m_next_mode(model_mode), 0);
    repeat (20) @(posedge clk);
    #1;
    check("freeze_leds", 32'(leds), 32'(model_leds));
    check("freeze_tick", 32'(tick), 32'd0);

    // Reset mid-run with count 9 in AUTO_UP, caught while tick is high
    press(4'b1000, 4'd0, 2'd0, 1);
    for (int i = 0; i < 9; i++) press(4'b0001, m_inc(model_leds), 2'd0, 1);
    press(4'b0100, 4'd9, 2'd1, 0);
    repeat (CPS - 1) @(posedge clk);
    #1;
    check("pre_rst_tick", 32'(tick), 32'd1);
    #2;
    expect_leds(4'd0);
    rst = 1'b1;
    #1;
    check("async_rst_leds", 32'(leds), 32'd0);
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_tick", 32'(tick), 32'd0);
    model_leds = 4'd0;
    model_mode = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    press(4'b0100, 4'd0, 2'd1, 0);
    auto_step(1'b1);

    // Button held across reset release gives no press until re-pressed
    @(negedge clk);
    expect_leds(4'd0);
    rst = 1'b1;
    buttons = 4'b0001;
    model_leds = 4'd0;
    model_mode = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("held_no_inc", 32'(leds), 32'd0);
    check("held_mode", 32'(mode), 32'd0);
    @(negedge clk);
    buttons = 4'd0;
    repeat (3) @(posedge clk);
    press(4'b0001, 4'd1, 2'd0, 1);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
